// File: rtl/add_serial_param.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle, LSB first, start/done handshake.
// Optional saturation of signed overflow is enabled by defining ADD_SERIAL_PARAM_SAT_EN.
module add_serial_param #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf
);

    localparam int NSTEP = WIDTH / DIGIT;
    localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic [CW-1:0] LAST_STEP = CW'(NSTEP - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [DIGIT:0]       sum_s;
    logic                 msb_cin_s;
    logic                 ovf_s;
    logic [WIDTH+DIGIT-1:0] shift_s;

    // Clamp value for a signed overflow; the wrapped sign bit tells its direction.
    function automatic logic [WIDTH-1:0] sat_value(input logic wrapped_msb);
        logic [WIDTH-1:0] v;
        if (wrapped_msb) begin
            v = {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            v = {1'b1, {(WIDTH-1){1'b0}}};
        end
        return v;
    endfunction

    // One digit of the ripple sum plus the signed-overflow term of its top bit.
    always_comb begin
        sum_s     = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
        msb_cin_s = sum_s[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
        ovf_s     = msb_cin_s ^ sum_s[DIGIT];
        shift_s   = {sum_s[DIGIT-1:0], out_q};
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        count_d = count_q;
        out_d   = out_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub;
                    count_d = {CW{1'b0}};
                    out_d   = {WIDTH{1'b0}};
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                out_d   = shift_s[WIDTH+DIGIT-1:DIGIT];
                carry_d = sum_s[DIGIT];
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
                if (count_q == LAST_STEP) begin
                    cout_d  = sum_s[DIGIT];
                    ovf_d   = ovf_s;
                    state_d = ST_DONE;
`ifdef ADD_SERIAL_PARAM_SAT_EN
                    if (ovf_s) begin
                        out_d = sat_value(sum_s[DIGIT-1]);
                    end else begin
                        out_d = shift_s[WIDTH+DIGIT-1:DIGIT];
                    end
`endif
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            count_q <= {CW{1'b0}};
            out_q   <= {WIDTH{1'b0}};
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            count_q <= count_d;
            out_q   <= out_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

    // sat_value is referenced only in the saturating build.
    logic unused_s;
    assign unused_s = ^sat_value(1'b0);

endmodule

// File: tb/tb_add_serial_param.sv
// Directed bench for add_serial_param: an 8-bit bit-serial instance and a 16-bit nibble-serial instance.
module tb_add_serial_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start8 = 1'b0, sub8 = 1'b0;
    logic [7:0]  a8 = 8'h00, b8 = 8'h00;
    logic        busy8, done8, cout8, ovf8;
    logic [7:0]  out8;

    logic        start16 = 1'b0, sub16 = 1'b0;
    logic [15:0] a16 = 16'h0000, b16 = 16'h0000;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] out16;

    int n_checks = 0;
    int n_fail   = 0;

    add_serial_param #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .out(out8), .cout(cout8), .ovf(ovf8)
    );

    add_serial_param #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .out(out16), .cout(cout16), .ovf(ovf16)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Waits (bounded) for done8; 'elapsed' cycles have already passed since the accepting edge.
    task automatic wait_done8(input string tag, input int elapsed);
        int cyc;
        cyc = elapsed;
        while (!done8 && cyc < 40) begin
            tick();
            cyc++;
        end
        chk({tag, "_done"}, {31'd0, done8}, 32'd1);
        chk({tag, "_latency"}, cyc, 32'd9);
    endtask

    task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv, input logic sv,
                       input logic [7:0] exp_out, input logic exp_cout, input logic exp_ovf);
        a8 = av; b8 = bv; sub8 = sv; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        wait_done8(tag, 1);
        chk({tag, "_out"}, {24'd0, out8}, {24'd0, exp_out});
        chk({tag, "_cout"}, {31'd0, cout8}, {31'd0, exp_cout});
        chk({tag, "_ovf"}, {31'd0, ovf8}, {31'd0, exp_ovf});
    endtask

    initial begin
        logic saw_done;
        tick();
        tick();
        chk("rst_busy", {31'd0, busy8}, 32'd0);
        chk("rst_done", {31'd0, done8}, 32'd0);
        chk("rst_out", {24'd0, out8}, 32'd0);
        chk("rst_flags", {30'd0, cout8, ovf8}, 32'd0);
        rst = 1'b0;
        tick();

        // 0x35 + 0x4A: busy exactly 8 cycles, done in the 9th.
        a8 = 8'h35; b8 = 8'h4A; sub8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("add1_busy", {30'd0, busy8, done8}, 32'd2);
            tick();
        end
        chk("add1_done", {30'd0, busy8, done8}, 32'd1);
        chk("add1_out", {24'd0, out8}, 32'h7F);
        chk("add1_flags", {30'd0, cout8, ovf8}, 32'd0);
        tick();
        chk("add1_idle", {30'd0, busy8, done8}, 32'd0);
        chk("add1_hold", {24'd0, out8}, 32'h7F);

        op8("ffp1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        op8("sub", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
        tick();
`ifdef ADD_SERIAL_PARAM_SAT_EN
        op8("posovf", 8'h7F, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        tick();
        op8("negovf", 8'h80, 8'h01, 1'b1, 8'h80, 1'b1, 1'b1);
`else
        op8("posovf", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        tick();
        op8("negovf", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
`endif
        tick();

        // Reset during the 3rd RUN cycle aborts without a done pulse.
        a8 = 8'h0F; b8 = 8'h01; sub8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", {30'd0, busy8, done8}, 32'd0);
        chk("abort_out", {24'd0, out8}, 32'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            saw_done = saw_done | done8;
            tick();
        end
        chk("abort_nodone", {31'd0, saw_done}, 32'd0);
        op8("after_abort", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);
        tick();

        // start and operand changes during RUN must be ignored.
        a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1;
        tick();
        start8 = 1'b0; a8 = 8'hAA;
        tick();
        start8 = 1'b1; b8 = 8'h55;
        tick();
        start8 = 1'b0;
        wait_done8("ignore", 5);
        chk("ignore_out", {24'd0, out8}, 32'h46);
        chk("ignore_flags", {30'd0, cout8, ovf8}, 32'd0);
        tick();

        // 16-bit, 4-bit digits: back-to-back with start held in DONE.
        a16 = 16'h1234; b16 = 16'h0FFF; sub16 = 1'b0; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("w16_busy", {30'd0, busy16, done16}, 32'd2);
            tick();
        end
        chk("w16_done", {30'd0, busy16, done16}, 32'd1);
        chk("w16_out", {16'd0, out16}, 32'h2233);
        chk("w16_flags", {30'd0, cout16, ovf16}, 32'd0);
        a16 = 16'hFFFF; b16 = 16'h0002; sub16 = 1'b1; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        chk("w16_b2b_busy", {30'd0, busy16, done16}, 32'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("w16_b2b_run", {30'd0, busy16, done16}, 32'd2);
        end
        tick();
        chk("w16_b2b_done", {30'd0, busy16, done16}, 32'd1);
        chk("w16_b2b_out", {16'd0, out16}, 32'h0000FFFD);
        chk("w16_b2b_flags", {30'd0, cout16, ovf16}, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
